// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS MEM stage slice.
package mips_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } memState_t;

endpackage : mips_pkg

// File: rtl/memory_access_mips_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
interface memory_access_mips_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  memRequest;
    logic                  memWrite;
    logic [DATA_WIDTH-1:0] memAddress;
    logic [DATA_WIDTH-1:0] memWriteData;
    logic                  memAcknowledge;
    logic [DATA_WIDTH-1:0] memReadData;

    modport master (
        output memRequest,
        output memWrite,
        output memAddress,
        output memWriteData,
        input  memAcknowledge,
        input  memReadData
    );

    modport slave (
        input  memRequest,
        input  memWrite,
        input  memAddress,
        input  memWriteData,
        output memAcknowledge,
        output memReadData
    );
endinterface : memory_access_mips_if

// File: rtl/mem_handshake_fsm.sv
// Request/acknowledge sequencer for the MEM stage: owns state, memRequest and stall.
// Optional BUSY timeout abort when MEM_TIMEOUT_EN is defined.
module mem_handshake_fsm
    import mips_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic clock,
    input  logic resetMachine,
    input  logic memOp_i,
    input  logic memAcknowledge_i,
    output logic memRequest_o,
    output logic memError_o,
    output logic stall_c,
    output logic issue_c,
    output logic complete_c,
    output logic abort_c
);

    memState_t state_q;
    logic      busy;
    logic      timeoutHit;

    assign busy = (state_q == MEM_BUSY);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_WIDTH-1:0] busyCount_q;

    assign timeoutHit = busy && !memAcknowledge_i
                        && (busyCount_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    // Counts completed BUSY cycles; cleared when a request is issued.
    always_ff @(posedge clock or posedge resetMachine) begin
        if (resetMachine) begin
            busyCount_q <= '0;
        end else if (issue_c) begin
            busyCount_q <= '0;
        end else if (busy) begin
            busyCount_q <= busyCount_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge resetMachine) begin
        if (resetMachine) begin
            memError_o <= 1'b0;
        end else begin
            memError_o <= abort_c;
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign memError_o = 1'b0;
`endif

    // Stall is gated by reset so an in-flight op cannot hold the pipe during reset.
    always_comb begin
        issue_c    = 1'b0;
        complete_c = 1'b0;
        abort_c    = 1'b0;
        stall_c    = 1'b0;
        if (!busy) begin
            issue_c = memOp_i;
        end else begin
            complete_c = memAcknowledge_i;
            abort_c    = timeoutHit;
        end
        stall_c = !resetMachine && (issue_c || (busy && !memAcknowledge_i && !timeoutHit));
    end

    always_ff @(posedge clock or posedge resetMachine) begin
        if (resetMachine) begin
            state_q      <= MEM_IDLE;
            memRequest_o <= 1'b0;
        end else begin
            case (state_q)
                MEM_IDLE: begin
                    if (memOp_i) begin
                        state_q      <= MEM_BUSY;
                        memRequest_o <= 1'b1;
                    end
                end
                MEM_BUSY: begin
                    if (memAcknowledge_i || timeoutHit) begin
                        state_q      <= MEM_IDLE;
                        memRequest_o <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= MEM_IDLE;
                    memRequest_o <= 1'b0;
                end
            endcase
        end
    end

endmodule : mem_handshake_fsm

// File: rtl/memory_access_mips.sv
// MIPS MEM pipeline stage: drives the data-memory handshake and registers MEM/WB.
// Build option: MEM_TIMEOUT_EN adds a BUSY timeout abort with memError_Memory pulse.
module memory_access_mips
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = mips_pkg::DATA_WIDTH
`ifdef MEM_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                      clock,
    input  logic                      resetMachine,
    input  logic                      enableWriteRegisterFile_Execute,
    input  logic [REG_ADDR_WIDTH-1:0] addressWriteRegisterFile_Execute,
    input  logic                      controlSignalWriteFromDataMemoryRegisterFile_Execute,
    input  logic [DATA_WIDTH-1:0]     resultALU_Execute,
    input  logic                      enableReadDataMemory_Execute,
    input  logic                      enableWriteDataMemory_Execute,
    input  logic [DATA_WIDTH-1:0]     dataToWriteDataMemory_Execute,
    input  logic [DATA_WIDTH-1:0]     instruction_Execute,
    memory_access_mips_if.master      mem_bus,
    output logic                      stallPipeline_Memory,
    output logic                      enableWriteRegisterFile_Memory,
    output logic [REG_ADDR_WIDTH-1:0] addressWriteRegisterFile_Memory,
    output logic [DATA_WIDTH-1:0]     dataWriteRegisterFile_Memory,
    output logic [DATA_WIDTH-1:0]     instruction_Memory,
    output logic                      memError_Memory
);

    logic memOp;
    logic memRequest;
    logic issue_c;
    logic complete_c;
    logic abort_c;

    logic                      memWrite_q;
    logic [DATA_WIDTH-1:0]     memAddress_q;
    logic [DATA_WIDTH-1:0]     memWriteData_q;
    logic                      wbEnable_q;
    logic [REG_ADDR_WIDTH-1:0] wbAddress_q;
    logic [DATA_WIDTH-1:0]     wbData_q;
    logic [DATA_WIDTH-1:0]     wbInstruction_q;

    assign memOp = enableReadDataMemory_Execute || enableWriteDataMemory_Execute;

    mem_handshake_fsm
`ifdef MEM_TIMEOUT_EN
    #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
    u_fsm (
        .clock            (clock),
        .resetMachine     (resetMachine),
        .memOp_i          (memOp),
        .memAcknowledge_i (mem_bus.memAcknowledge),
        .memRequest_o     (memRequest),
        .memError_o       (memError_Memory),
        .stall_c          (stallPipeline_Memory),
        .issue_c          (issue_c),
        .complete_c       (complete_c),
        .abort_c          (abort_c)
    );

    // Bus payload is captured at issue and held for the whole transaction; write wins on read+write.
    always_ff @(posedge clock or posedge resetMachine) begin
        if (resetMachine) begin
            memWrite_q     <= 1'b0;
            memAddress_q   <= '0;
            memWriteData_q <= '0;
        end else if (issue_c) begin
            memWrite_q     <= enableWriteDataMemory_Execute;
            memAddress_q   <= {resultALU_Execute[DATA_WIDTH-1:2], 2'b00};
            memWriteData_q <= dataToWriteDataMemory_Execute;
        end else if (complete_c || abort_c) begin
            memWrite_q     <= 1'b0;
            memAddress_q   <= '0;
            memWriteData_q <= '0;
        end
    end

    // MEM/WB: pass-through when idle, bubble on issue/abort, hold while waiting, resolve on ack.
    always_ff @(posedge clock or posedge resetMachine) begin
        if (resetMachine) begin
            wbEnable_q      <= 1'b0;
            wbAddress_q     <= '0;
            wbData_q        <= '0;
            wbInstruction_q <= '0;
        end else if (complete_c) begin
            wbEnable_q      <= enableWriteRegisterFile_Execute && !enableWriteDataMemory_Execute;
            wbAddress_q     <= addressWriteRegisterFile_Execute;
            wbData_q        <= controlSignalWriteFromDataMemoryRegisterFile_Execute
                               ? mem_bus.memReadData : resultALU_Execute;
            wbInstruction_q <= instruction_Execute;
        end else if (issue_c || abort_c) begin
            wbEnable_q      <= 1'b0;
            wbAddress_q     <= '0;
            wbData_q        <= '0;
            wbInstruction_q <= '0;
        end else if (!memRequest) begin
            wbEnable_q      <= enableWriteRegisterFile_Execute;
            wbAddress_q     <= addressWriteRegisterFile_Execute;
            wbData_q        <= controlSignalWriteFromDataMemoryRegisterFile_Execute
                               ? '0 : resultALU_Execute;
            wbInstruction_q <= instruction_Execute;
        end
    end

    assign mem_bus.memRequest   = memRequest;
    assign mem_bus.memWrite     = memWrite_q;
    assign mem_bus.memAddress   = memAddress_q;
    assign mem_bus.memWriteData = memWriteData_q;

    assign enableWriteRegisterFile_Memory  = wbEnable_q;
    assign addressWriteRegisterFile_Memory = wbAddress_q;
    assign dataWriteRegisterFile_Memory    = wbData_q;
    assign instruction_Memory              = wbInstruction_q;

endmodule : memory_access_mips

// File: tb/tb_memory_access_mips.sv
// Self-checking bench for memory_access_mips; scoreboard of expected MEM/WB results.
module tb_memory_access_mips;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] instr;
    } wb_t;

    logic        clock;
    logic        resetMachine;
    logic        wrRf;
    logic [4:0]  dest;
    logic        selMem;
    logic [31:0] alu;
    logic        rdMem;
    logic        wrMem;
    logic [31:0] storeData;
    logic [31:0] instr;
    logic        stall;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic [31:0] wbInstr;
    logic        memError;

    int errors = 0;
    int checks = 0;
    wb_t sb_q[$];

    memory_access_mips_if #(.DATA_WIDTH(32)) mem_bus ();

    memory_access_mips #(
        .DATA_WIDTH(32)
`ifdef MEM_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clock                                                (clock),
        .resetMachine                                         (resetMachine),
        .enableWriteRegisterFile_Execute                      (wrRf),
        .addressWriteRegisterFile_Execute                     (dest),
        .controlSignalWriteFromDataMemoryRegisterFile_Execute (selMem),
        .resultALU_Execute                                    (alu),
        .enableReadDataMemory_Execute                         (rdMem),
        .enableWriteDataMemory_Execute                        (wrMem),
        .dataToWriteDataMemory_Execute                        (storeData),
        .instruction_Execute                                  (instr),
        .mem_bus                                              (mem_bus),
        .stallPipeline_Memory                                 (stall),
        .enableWriteRegisterFile_Memory                       (wbEn),
        .addressWriteRegisterFile_Memory                      (wbAddr),
        .dataWriteRegisterFile_Memory                         (wbData),
        .instruction_Memory                                   (wbInstr),
        .memError_Memory                                      (memError)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic wb_t wb_now();
        wb_t w;
        w.en    = wbEn;
        w.addr  = wbAddr;
        w.data  = wbData;
        w.instr = wbInstr;
        return w;
    endfunction

    task automatic drive(input logic w, input logic [4:0] d, input logic s, input logic [31:0] a,
                         input logic r, input logic wm, input logic [31:0] sd, input logic [31:0] ins);
        wrRf = w; dest = d; selMem = s; alu = a; rdMem = r; wrMem = wm; storeData = sd; instr = ins;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        wb_t got;
        resetMachine = 1'b1;
        mem_bus.memAcknowledge = 1'b0;
        mem_bus.memReadData = 32'h0;
        drive(1'b1, 5'd9, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 32'h8C000040);
        @(negedge clock);
        got = wb_now();
        checks++;
        if ({got, mem_bus.memRequest, mem_bus.memWrite, mem_bus.memAddress, mem_bus.memWriteData,
             stall, memError} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got wb=%h req=%b stall=%b err=%b expected all zero",
                     got, mem_bus.memRequest, stall, memError);
        end
        step();
        nop();
        resetMachine = 1'b0;
        step();
    endtask

    task automatic test_alu();
        wb_t got;
        wb_t exp;
        drive(1'b1, 5'd5, 1'b0, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h00A52820);
        sb_q.push_back('{1'b1, 5'd5, 32'h1234, 32'h00A52820});
        @(negedge clock);
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL alu_stall: got %b expected 0", stall);
        end
        step();
        // load-select on a non-memory op writes zero
        drive(1'b1, 5'd6, 1'b1, 32'h5678, 1'b0, 1'b0, 32'h0, 32'h00C63020);
        sb_q.push_back('{1'b1, 5'd6, 32'h0, 32'h00C63020});
        @(negedge clock);
        got = wb_now(); exp = sb_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL alu_wb: got %h expected %h", got, exp);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL alu_b2b_stall: got %b expected 0", stall);
        end
        step();
        nop();
        @(negedge clock);
        got = wb_now(); exp = sb_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL alu_sel_wb: got %h expected %h", got, exp);
        end
        step();
    endtask

    task automatic test_load(input logic [31:0] addr, input logic [4:0] d, input logic [31:0] rdata,
                             input logic [31:0] ins);
        wb_t got;
        wb_t exp;
        drive(1'b1, d, 1'b1, addr, 1'b1, 1'b0, 32'h0, ins);
        sb_q.push_back('{1'b1, d, rdata, ins});
        @(negedge clock);
        checks++;
        if ({stall, mem_bus.memRequest} !== 2'b10) begin
            errors++; $display("FAIL load_issue: got stall=%b req=%b expected stall=1 req=0",
                               stall, mem_bus.memRequest);
        end
        step();
        mem_bus.memAcknowledge = 1'b1;
        mem_bus.memReadData = rdata;
        @(negedge clock);
        checks++;
        if ({mem_bus.memRequest, mem_bus.memWrite, mem_bus.memAddress} !==
            {1'b1, 1'b0, addr[31:2], 2'b00}) begin
            errors++; $display("FAIL load_bus: got req=%b wr=%b addr=%h expected 1 0 %h",
                               mem_bus.memRequest, mem_bus.memWrite, mem_bus.memAddress,
                               {addr[31:2], 2'b00});
        end
        checks++;
        if ({wbEn, wbInstr, stall} !== '0) begin
            errors++; $display("FAIL load_bubble: got en=%b instr=%h stall=%b expected 0",
                               wbEn, wbInstr, stall);
        end
        step();
        mem_bus.memAcknowledge = 1'b0;
        mem_bus.memReadData = 32'h0;
        nop();
        @(negedge clock);
        got = wb_now(); exp = sb_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL load_wb: got %h expected %h", got, exp);
        end
        checks++;
        if (mem_bus.memRequest !== 1'b0) begin
            errors++; $display("FAIL load_req_drop: got %b expected 0", mem_bus.memRequest);
        end
        step();
    endtask

    task automatic test_store(input logic rd, input logic [31:0] addr, input logic [31:0] sd,
                              input int waits);
        wb_t got;
        wb_t exp;
        int stallCnt = 0;
        logic busOk = 1'b1;
        drive(1'b1, 5'd10, 1'b0, addr, rd, 1'b1, sd, 32'hAD0A0000);
        sb_q.push_back('{1'b0, 5'd10, addr, 32'hAD0A0000});
        @(negedge clock);
        if (stall === 1'b1) stallCnt++;
        step();
        for (int i = 0; i < waits; i++) begin
            @(negedge clock);
            if (stall === 1'b1) stallCnt++;
            if ({mem_bus.memRequest, mem_bus.memWrite, mem_bus.memAddress, mem_bus.memWriteData} !==
                {1'b1, 1'b1, addr[31:2], 2'b00, sd}) busOk = 1'b0;
            step();
        end
        mem_bus.memAcknowledge = 1'b1;
        @(negedge clock);
        if (stall === 1'b1) stallCnt++;
        step();
        mem_bus.memAcknowledge = 1'b0;
        nop();
        @(negedge clock);
        checks++;
        if (busOk !== 1'b1) begin
            errors++; $display("FAIL store_bus: got held bus ok=%b expected 1 (addr %h data %h)",
                               busOk, {addr[31:2], 2'b00}, sd);
        end
        checks++;
        if (stallCnt != waits + 1) begin
            errors++; $display("FAIL store_stall_cycles: got %0d expected %0d", stallCnt, waits + 1);
        end
        got = wb_now(); exp = sb_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL store_wb: got %h expected %h", got, exp);
        end
        step();
    endtask

    task automatic test_spurious_ack();
        wb_t got;
        wb_t exp;
        mem_bus.memAcknowledge = 1'b1;
        mem_bus.memReadData = 32'hFFFF0000;
        drive(1'b1, 5'd3, 1'b0, 32'h55, 1'b0, 1'b0, 32'h0, 32'h00031820);
        sb_q.push_back('{1'b1, 5'd3, 32'h55, 32'h00031820});
        @(negedge clock);
        checks++;
        if ({mem_bus.memRequest, stall} !== 2'b00) begin
            errors++; $display("FAIL spurious_ack_idle: got req=%b stall=%b expected 0 0",
                               mem_bus.memRequest, stall);
        end
        step();
        mem_bus.memAcknowledge = 1'b0;
        nop();
        @(negedge clock);
        got = wb_now(); exp = sb_q.pop_front();
        checks++;
        if ({got, mem_bus.memRequest} !== {exp, 1'b0}) begin
            errors++; $display("FAIL spurious_ack_wb: got %h req=%b expected %h req=0",
                               got, mem_bus.memRequest, exp);
        end
        step();
    endtask

    task automatic test_reset_busy();
        wb_t got;
        drive(1'b1, 5'd11, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 32'h8D6B0300);
        step();
        @(negedge clock);
        checks++;
        if (mem_bus.memRequest !== 1'b1) begin
            errors++; $display("FAIL rst_busy_pre: got req=%b expected 1", mem_bus.memRequest);
        end
        #2 resetMachine = 1'b1;
        #1;
        got = wb_now();
        checks++;
        if ({got, mem_bus.memRequest, mem_bus.memWrite, mem_bus.memAddress, stall, memError} !== '0) begin
            errors++; $display("FAIL rst_busy_async: got wb=%h req=%b addr=%h stall=%b expected all zero",
                               got, mem_bus.memRequest, mem_bus.memAddress, stall);
        end
        step();
        resetMachine = 1'b0;
        nop();
        mem_bus.memAcknowledge = 1'b1;
        mem_bus.memReadData = 32'h12345678;
        @(negedge clock);
        step();
        mem_bus.memAcknowledge = 1'b0;
        @(negedge clock);
        got = wb_now();
        checks++;
        if ({mem_bus.memRequest, stall, got.en} !== 3'b000) begin
            errors++; $display("FAIL rst_late_ack: got req=%b stall=%b en=%b expected 0 0 0",
                               mem_bus.memRequest, stall, got.en);
        end
        step();
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        logic earlyOk = 1'b1;
        drive(1'b1, 5'd12, 1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 32'h8D8C0400);
        step();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            if (mem_bus.memRequest !== 1'b1 || memError !== 1'b0) earlyOk = 1'b0;
            if (k < 4 && stall !== 1'b1) earlyOk = 1'b0;
            if (k == 4) begin
                checks++;
                if (stall !== 1'b0) begin
                    errors++; $display("FAIL timeout_stall_release: got %b expected 0", stall);
                end
            end
            if (k < 4) step();
        end
        checks++;
        if (earlyOk !== 1'b1) begin
            errors++; $display("FAIL timeout_busy_window: got ok=%b expected 1", earlyOk);
        end
        step();
        nop();
        @(negedge clock);
        checks++;
        if ({memError, mem_bus.memRequest, wbEn, stall} !== 4'b1000) begin
            errors++; $display("FAIL timeout_abort: got err=%b req=%b en=%b stall=%b expected 1 0 0 0",
                               memError, mem_bus.memRequest, wbEn, stall);
        end
        step();
        @(negedge clock);
        checks++;
        if (memError !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse_width: got %b expected 0", memError);
        end
        step();
    endtask
`else
    task automatic test_long_wait();
        wb_t got;
        wb_t exp;
        logic holdOk = 1'b1;
        drive(1'b1, 5'd13, 1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 32'h8DAD0500);
        sb_q.push_back('{1'b1, 5'd13, 32'hCAFEF00D, 32'h8DAD0500});
        step();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if ({mem_bus.memRequest, stall, memError} !== 3'b110) holdOk = 1'b0;
            step();
        end
        mem_bus.memAcknowledge = 1'b1;
        mem_bus.memReadData = 32'hCAFEF00D;
        step();
        mem_bus.memAcknowledge = 1'b0;
        nop();
        @(negedge clock);
        checks++;
        if (holdOk !== 1'b1) begin
            errors++; $display("FAIL long_wait_hold: got ok=%b expected 1", holdOk);
        end
        got = wb_now(); exp = sb_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL long_wait_wb: got %h expected %h", got, exp);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load(32'h100, 5'd8, 32'hDEADBEEF, 32'h8D080100);
        test_store(1'b0, 32'h103, 32'hA5A5A5A5, 3);
        test_store(1'b1, 32'h200, 32'h11111111, 0);
        test_spurious_ack();
        test_reset_busy();
        test_load(32'h2C6, 5'd15, 32'h0BADF00D, 32'h8DEF02C6);
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_load(32'h604, 5'd17, 32'h600DCAFE, 32'h8E310604);
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_memory_access_mips
